// File: rtl/led_chaser_pkg.sv
// Shared definitions for the LED chaser family (left-to-right and right-to-left).
// Holds the FSM state type, the mode encodings, the LED bank width and a pattern helper.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLASH = 2'd2
  } chase_state_t;

  localparam logic [1:0] MODE_DOT  = 2'b00;
  localparam logic [1:0] MODE_FILL = 2'b01;

  localparam int LED_W = 8;

  // FILL builds (2 << pos) - 1 one bit wider than the bank so pos = 7 yields all ones.
  function automatic logic [LED_W-1:0] chase_pattern(input logic fill, input logic [2:0] pos);
    logic [LED_W:0] wide;
    if (fill) wide = ((LED_W+1)'(2) << pos) - (LED_W+1)'(1);
    else      wide = (LED_W+1)'(1) << pos;
    return wide[LED_W-1:0];
  endfunction

endpackage

// File: rtl/step_divider.sv
// Prescaler producing one tick every CLK_DIV cycles while run is high.
// clr restarts the count so a new frame always lasts the full CLK_DIV cycles.
module step_divider #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_right_to_left.sv
// Right-to-left LED chaser: sweeps a dot or fill pattern from bit 0 to bit 7,
// then shows a one-step flash frame before the next sweep.
module led_right_to_left
  import led_chaser_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] LED8,
  output logic             step,
  output logic             wrap
);

  chase_state_t     state, state_n;
  logic [2:0]       pos, pos_n;
  logic             cur_mode, cur_mode_n;
  logic [LED_W-1:0] led_n;
  logic             step_n, wrap_n;
  logic             tick;
  logic             div_clr;
  logic             div_run;

  // Divider is held at zero outside a sweep so the first frame gets a full step.
  assign div_run = (state != IDLE);
  assign div_clr = (state == IDLE) || !en;

  step_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (div_clr),
    .run  (div_run),
    .tick (tick)
  );

  always_comb begin
    state_n    = state;
    pos_n      = pos;
    cur_mode_n = cur_mode;
    led_n      = LED8;
    step_n     = 1'b0;
    wrap_n     = 1'b0;
    unique case (state)
      IDLE: begin
        led_n = '0;
        if (en) begin
          state_n    = RUN;
          pos_n      = 3'd0;
          cur_mode_n = (mode == MODE_FILL);
          led_n      = chase_pattern(cur_mode_n, 3'd0);
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          pos_n   = 3'd0;
          led_n   = '0;
        end else if (tick) begin
          step_n = 1'b1;
          if (pos == 3'd7) begin
            state_n = FLASH;
            wrap_n  = 1'b1;
            led_n   = cur_mode ? {LED_W{1'b0}} : {LED_W{1'b1}};
          end else begin
            pos_n = pos + 3'd1;
            led_n = chase_pattern(cur_mode, pos_n);
          end
        end
      end
      FLASH: begin
        if (!en) begin
          state_n = IDLE;
          pos_n   = 3'd0;
          led_n   = '0;
        end else if (tick) begin
          // Mode is only sampled as a new sweep starts, so mid-sweep changes stay invisible.
          step_n     = 1'b1;
          state_n    = RUN;
          pos_n      = 3'd0;
          cur_mode_n = (mode == MODE_FILL);
          led_n      = chase_pattern(cur_mode_n, 3'd0);
        end
      end
      default: begin
        state_n = IDLE;
        pos_n   = 3'd0;
        led_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= 3'd0;
      cur_mode <= 1'b0;
      LED8     <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      cur_mode <= cur_mode_n;
      LED8     <= led_n;
      step     <= step_n;
      wrap     <= wrap_n;
    end
  end

endmodule
